uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Oversampling UART receiver controller: detects a start bit on the serial line, samples each bit at mid-period with 3-sample majority voting, deserializes LSB-first data, checks optional parity and the stop bit, and emits the received word with a one-cycle valid pulse. It sits on the RX side of the UART, opposite the TX framing FSM, and runs on the oversampled UART clock (prescale × baud).

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `PRESCALE_W`, 6: width of the prescale input.

- `clk` in 1: oversampled UART clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rx_in` in 1: serial line, idle high.
- `par_en` in 1: parity bit present in frame.
- `par_typ` in 1: 0 = even, 1 = odd parity.
- `prescale` in PRESCALE_W: oversampling ratio; legal values 8, 16, 32.
- `data_out` out DATA_WIDTH: last good received word.
- `data_valid` out 1: one-cycle pulse, `data_out` newly updated.
- `par_err` out 1: parity mismatch on current/last frame.
- `stp_err` out 1: stop bit sampled low on current/last frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- `edge_cnt` counts 0..P-1 within a bit; `bit_cnt` counts data bits 0..DATA_WIDTH-1.
- `prescale`, `par_en`, `par_typ` latched on START entry; changes mid-frame have no effect. Any prescale other than 16 or 32 is treated as 8.
- Sampler: `rx_in` captured at edge_cnt P/2-1, P/2, P/2+1; bit value = majority of the three; valid from edge P/2+2 onward.
- IDLE: `rx_in`==0 counts as edge 0 -> START with edge_cnt=1.
- START: at edge P-1 -> DATA (see Configuration for glitch check).
- DATA: sampled bit shifted in LSB-first at edge P-1; after bit DATA_WIDTH-1 -> PARITY if par_en else STOP.
- PARITY: at edge P-1 compare sampled bit with computed parity of shifted word; mismatch sets `par_err`. -> STOP.
- STOP: at edge P-1, sampled 0 sets `stp_err`. -> DONE.
- DONE (1 cycle): if no error, `data_out` <= shift register and `data_valid`=1; if `rx_in`==0, DONE counts as edge 0 of next start bit -> START with edge_cnt=1; else -> IDLE.
- Errored frame: `data_out` unchanged, `data_valid` stays 0.
- `par_err`/`stp_err` held until next START entry, where both clear.

## Timing
- Reset: state IDLE, counters 0, `data_out`=0, `data_valid`=0, `par_err`=0, `stp_err`=0.
- Reset mid-frame: immediate return to IDLE, partial word discarded, no pulse.
- Latency: falling edge of start bit to `data_valid` = (1 + DATA_WIDTH + par_en + 1)·P cycles (DONE is the cycle after stop edge P-1).
- Back-to-back frames with no idle gap are received without loss.
- `data_valid` never asserted for two consecutive cycles.
- All outputs registered.

## Configuration
- `UART_RX_START_CHECK_EN` defined: at START edge P/2+2, majority sample of 1 is a glitch -> IDLE, no flags changed.
- Undefined: START always proceeds to DATA at edge P-1 regardless of sampled value.

## Structure
- Package `uart_rx_pkg`: state enum, legal prescale constants (8/16/32), parity-type constants.
- Sub-module `uart_rx_sampler`: three-sample capture and majority vote, driven by `edge_cnt` and latched prescale.
- Counters, shift register, parity/stop checks and FSM stay in `uart_rx_ctrl`.

## Test plan
- P=8, par_en=0, frame 0xA5 -> `data_out`=0xA5, one `data_valid` pulse 80 cycles after start edge, no flags.
- P=16, par_en=1, par_typ=0, 0x3C with parity 0 -> valid; same with parity 1 -> `par_err`=1, no pulse, `data_out` unchanged.
- P=32, stop bit driven low -> `stp_err`=1, no pulse; next good frame clears flag at its START.
- Two back-to-back frames 0x01, 0xFF at P=8 -> two pulses exactly 80 cycles apart, both words correct.
- Single-cycle glitch on one of three samples per bit -> majority recovers correct 0x5A.
- With macro: 2-cycle low pulse on idle line -> returns IDLE, no pulse; reset asserted mid-DATA -> all outputs 0, next frame received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } state_e;

   typedef enum logic {
      PAR_EVEN = 1'b0,
      PAR_ODD  = 1'b1
   } par_typ_e;

   localparam int unsigned PRESCALE_8  = 8;
   localparam int unsigned PRESCALE_16 = 16;
   localparam int unsigned PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point mid-bit capture with majority vote; output is settled from edge P/2+2.
module uart_rx_sampler
   import uart_rx_pkg::*;
#(
   parameter int unsigned PRESCALE_W = 6
)(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_rx,
   input  logic                  i_en,
   input  logic [PRESCALE_W-1:0] i_edge_cnt,
   input  logic [PRESCALE_W-1:0] i_prescale,
   output logic                  o_bit
);

   logic [PRESCALE_W-1:0] w_half;
   logic [2:0]            r_smp;

   assign w_half = i_prescale >> 1;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_smp <= 3'b111;
      end else if (i_en) begin
         if (i_edge_cnt == w_half - PRESCALE_W'(1)) r_smp[0] <= i_rx;
         if (i_edge_cnt == w_half)                  r_smp[1] <= i_rx;
         if (i_edge_cnt == w_half + PRESCALE_W'(1)) r_smp[2] <= i_rx;
      end
   end

   assign o_bit = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, LSB-first deserialize, parity/stop checks.
// Optional start-bit glitch rejection enabled by defining UART_RX_START_CHECK_EN.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PRESCALE_W = 6
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_in,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);

   state_e                r_state;
   logic [PRESCALE_W-1:0] r_edge_cnt;
   logic [BIT_W-1:0]      r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [PRESCALE_W-1:0] r_p;
   logic                  r_par_en;
   par_typ_e              r_par_typ;

   logic [PRESCALE_W-1:0] w_p_dec;
   logic                  w_last;
   logic                  w_bit;
   logic                  w_par_exp;
   logic                  w_start;

   // Unsupported ratios fall back to 8x oversampling.
   assign w_p_dec = (prescale == PRESCALE_W'(PRESCALE_16)) ? PRESCALE_W'(PRESCALE_16) :
                    (prescale == PRESCALE_W'(PRESCALE_32)) ? PRESCALE_W'(PRESCALE_32) :
                                                             PRESCALE_W'(PRESCALE_8);
   assign w_last    = (r_edge_cnt == r_p - PRESCALE_W'(1));
   assign w_par_exp = (r_par_typ == PAR_ODD) ? ~(^r_shift) : (^r_shift);
   // A low line seen in IDLE or DONE is edge 0 of a start bit.
   assign w_start   = ((r_state == IDLE) || (r_state == DONE)) && !rx_in;

`ifdef UART_RX_START_CHECK_EN
   logic [PRESCALE_W-1:0] w_half;
   assign w_half = r_p >> 1;
`endif

   uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_rx       (rx_in),
      .i_en       (r_state != IDLE),
      .i_edge_cnt (r_edge_cnt),
      .i_prescale (r_p),
      .o_bit      (w_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_edge_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_p        <= PRESCALE_W'(PRESCALE_8);
         r_par_en   <= 1'b0;
         r_par_typ  <= PAR_EVEN;
         data_out   <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         r_edge_cnt <= w_last ? '0 : r_edge_cnt + PRESCALE_W'(1);
         case (r_state)
            IDLE: begin
               r_edge_cnt <= '0;
            end
            START: begin
               if (w_last) begin
                  r_state   <= DATA;
                  r_bit_cnt <= '0;
               end
`ifdef UART_RX_START_CHECK_EN
               else if ((r_edge_cnt == w_half + PRESCALE_W'(2)) && w_bit) begin
                  r_state    <= IDLE;
                  r_edge_cnt <= '0;
               end
`endif
            end
            DATA: begin
               if (w_last) begin
                  r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                  if (r_bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                     r_state <= r_par_en ? PARITY : STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                  end
               end
            end
            PARITY: begin
               if (w_last) begin
                  if (w_bit != w_par_exp) par_err <= 1'b1;
                  r_state <= STOP;
               end
            end
            STOP: begin
               if (w_last) begin
                  if (!w_bit) stp_err <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (!par_err && !stp_err) begin
                  data_out   <= r_shift;
                  data_valid <= 1'b1;
               end
               r_state    <= IDLE;
               r_edge_cnt <= '0;
            end
            default: begin
               r_state    <= IDLE;
               r_edge_cnt <= '0;
            end
         endcase
         // Start entry overrides the per-state updates above.
         if (w_start) begin
            r_state    <= START;
            r_edge_cnt <= PRESCALE_W'(1);
            r_p        <= w_p_dec;
            r_par_en   <= par_en;
            r_par_typ  <= par_typ_e'(par_typ);
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl.
module tb_uart_rx_ctrl;

   logic       clk;
   logic       rst;
   logic       rx_in;
   logic       par_en;
   logic       par_typ;
   logic [5:0] prescale;
   logic [7:0] data_out;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int vcount = 0;
   int dbl    = 0;
   int vcyc  [64];
   logic [7:0] vdata [64];
   logic prev_valid = 1'b0;

   int t0;
   int t0b;
   int vc;

   uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_in      (rx_in),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .prescale   (prescale),
      .data_out   (data_out),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Record every valid pulse with its cycle stamp and word.
   always @(negedge clk) begin
      if (data_valid) begin
         if (prev_valid) dbl = dbl + 1;
         if (vcount < 64) begin
            vcyc[vcount]  = cyc;
            vdata[vcount] = data_out;
         end
         vcount = vcount + 1;
      end
      prev_valid = data_valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge; each drive is seen by the following posedge.
   task automatic send_bit(input logic b, input int p, input logic glitch);
      for (int k = 0; k < p; k++) begin
         rx_in = (glitch && (k == p / 2)) ? ~b : b;
         @(negedge clk);
      end
   endtask

   task automatic send_body(input logic [7:0] d, input int p, input logic par_on,
                            input logic par_bit, input logic stop_bit, input logic glitch);
      for (int i = 0; i < 8; i++) send_bit(d[i], p, glitch);
      if (par_on) send_bit(par_bit, p, glitch);
      send_bit(stop_bit, p, glitch);
      rx_in = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input int p, input logic par_on,
                             input logic par_bit, input logic stop_bit, input logic glitch);
      t0 = cyc + 1;
      send_bit(1'b0, p, glitch);
      send_body(d, p, par_on, par_bit, stop_bit, glitch);
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst      = 1'b1;
      rx_in    = 1'b1;
      par_en   = 1'b0;
      par_typ  = 1'b0;
      prescale = 6'd8;
      repeat (3) @(negedge clk);
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_valid",    32'(data_valid), 32'h0);
      check("rst_par_err",  32'(par_err), 32'h0);
      check("rst_stp_err",  32'(stp_err), 32'h0);
      rst = 1'b0;
      idle(4);

      // P=8, no parity, 0xA5
      vc = vcount;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);
      check("p8_count",    32'(vcount), 32'(vc + 1));
      check("p8_latency",  32'(vcyc[vc] - t0), 32'd80);
      check("p8_data",     32'(vdata[vc]), 32'hA5);
      check("p8_par_err",  32'(par_err), 32'h0);
      check("p8_stp_err",  32'(stp_err), 32'h0);

      // P=16, even parity, 0x3C has four ones -> parity bit 0
      prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
      vc = vcount;
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(4);
      check("par_ok_count", 32'(vcount), 32'(vc + 1));
      check("par_ok_data",  32'(data_out), 32'h3C);
      check("par_ok_flag",  32'(par_err), 32'h0);

      vc = vcount;
      send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(4);
      check("par_bad_count", 32'(vcount), 32'(vc));
      check("par_bad_flag",  32'(par_err), 32'h1);
      check("par_bad_data",  32'(data_out), 32'h3C);

      // P=32, stop bit low
      prescale = 6'd32; par_en = 1'b0;
      vc = vcount;
      send_frame(8'h77, 32, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(4);
      check("stp_bad_count", 32'(vcount), 32'(vc));
      check("stp_bad_flag",  32'(stp_err), 32'h1);
      check("stp_bad_par",   32'(par_err), 32'h0);
      check("stp_bad_data",  32'(data_out), 32'h3C);

      // Next good frame clears the flag at its start bit
      t0 = cyc + 1;
      send_bit(1'b0, 32, 1'b0);
      check("stp_clear_at_start", 32'(stp_err), 32'h0);
      send_body(8'h12, 32, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);
      check("stp_good_count", 32'(vcount), 32'(vc + 1));
      check("stp_good_data",  32'(data_out), 32'h12);
      check("stp_good_flag",  32'(stp_err), 32'h0);

      // Back-to-back frames at P=8
      prescale = 6'd8;
      vc = vcount;
      send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1, 1'b0);
      t0b = t0;
      send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);
      check("b2b_count",   32'(vcount), 32'(vc + 2));
      check("b2b_data0",   32'(vdata[vc]), 32'h01);
      check("b2b_data1",   32'(vdata[vc + 1]), 32'hFF);
      check("b2b_lat0",    32'(vcyc[vc] - t0b), 32'd80);
      check("b2b_spacing", 32'(vcyc[vc + 1] - vcyc[vc]), 32'd80);

      // Middle-sample glitch on every bit, majority recovers the word
      vc = vcount;
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(4);
      check("glitch_count", 32'(vcount), 32'(vc + 1));
      check("glitch_data",  32'(data_out), 32'h5A);

      // Reset in the middle of DATA
      vc = vcount;
      send_bit(1'b0, 8, 1'b0);
      send_bit(1'b1, 8, 1'b0);
      send_bit(1'b0, 8, 1'b0);
      send_bit(1'b1, 8, 1'b0);
      rx_in = 1'b1;
      rst   = 1'b1;
      #1;
      check("mid_rst_data",  32'(data_out), 32'h0);
      check("mid_rst_valid", 32'(data_valid), 32'h0);
      check("mid_rst_par",   32'(par_err), 32'h0);
      check("mid_rst_stp",   32'(stp_err), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(4);
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);
      check("post_rst_count", 32'(vcount), 32'(vc + 1));
      check("post_rst_data",  32'(data_out), 32'hC3);

`ifdef UART_RX_START_CHECK_EN
      // Two-cycle low glitch on the idle line is rejected
      vc = vcount;
      rx_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      idle(100);
      check("start_glitch_count", 32'(vcount), 32'(vc));
      check("start_glitch_data",  32'(data_out), 32'hC3);
      send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);
      check("after_glitch_count", 32'(vcount), 32'(vc + 1));
      check("after_glitch_data",  32'(data_out), 32'h96);
`endif

      check("no_double_valid", 32'(dbl), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
